// File: rtl/beat_onset_detector_if.sv
`default_nettype none
// ============================================================================
// Module  : beat_onset_detector_if
// Brief   : Flux-in / flux-out / beat bundle between the onset detector and
//           its neighbours on the tempo path.
// Rev     : 1.0  initial release
// ============================================================================
interface beat_onset_detector_if #(
   parameter int W = 16
);
   logic         flux_in_valid;
   logic [W-1:0] flux_in_raw;
   logic         flux_valid;
   logic [W-1:0] flux_out;
   logic         beat_valid;
   logic [W-1:0] mean_out;
   logic [1:0]   state_out;

   modport master (
      output flux_in_valid, flux_in_raw,
      input  flux_valid, flux_out, beat_valid, mean_out, state_out
   );

   modport slave (
      input  flux_in_valid, flux_in_raw,
      output flux_valid, flux_out, beat_valid, mean_out, state_out
   );
endinterface
`default_nettype wire

// File: rtl/beat_onset_detector.sv
`default_nettype none
// ============================================================================
// Module  : beat_onset_detector
// Brief   : Running-mean adaptive-threshold beat flagger on spectral flux.
//           Optional macro ONSET_RISING_EDGE_EN adds a rising-slope term.
// Rev     : 1.0  initial release
// ============================================================================
module beat_onset_detector #(
   parameter int W            = 16,
   parameter int AVG_LEN      = 16,
   parameter int THRESH_NUM   = 3,
   parameter int THRESH_SHIFT = 1,
   parameter int MIN_FLUX     = 8,
   parameter int REFRACTORY   = 4
) (
   input  wire                   clk,
   input  wire                   reset,
   beat_onset_detector_if.slave  bus
);
   localparam int c_LOG2  = $clog2(AVG_LEN);
   localparam int c_SUM_W = W + c_LOG2;
   localparam int c_CMP_W = W + 4;
   localparam logic [c_CMP_W-1:0] c_NUM     = c_CMP_W'(THRESH_NUM);
   localparam logic [W-1:0]       c_MIN     = W'(MIN_FLUX);
   localparam logic [7:0]         c_REFR    = 8'(REFRACTORY);
   localparam logic [c_LOG2-1:0]  c_WP_LAST = c_LOG2'(AVG_LEN - 1);

   typedef enum logic [1:0] {
      ST_WARMUP  = 2'd0,
      ST_ARMED   = 2'd1,
      ST_REFRACT = 2'd2
   } state_t;

   logic [W-1:0]       r_buf [AVG_LEN];
   logic [c_LOG2-1:0]  r_wp;
   logic [c_SUM_W-1:0] r_sum;
   logic [7:0]         r_rcnt;
   state_t             r_state;
   logic               r_flux_valid;
   logic               r_beat_valid;
   logic [W-1:0]       r_flux_out;

   logic [W-1:0]       w_mean;
   logic [c_CMP_W-1:0] w_prod;
   logic [c_CMP_W-1:0] w_thr;
   logic [c_SUM_W-1:0] w_sum_next;
   logic               w_above;
   logic               w_floor;
   logic               w_rise;
   logic               w_beat;

   // Mean and threshold come from the history before the current sample lands
   assign w_mean     = r_sum[c_SUM_W-1:c_LOG2];
   assign w_prod     = {4'b0, w_mean} * c_NUM;
   assign w_thr      = w_prod >> THRESH_SHIFT;
   assign w_above    = {4'b0, bus.flux_in_raw} > w_thr;
   assign w_floor    = bus.flux_in_raw >= c_MIN;
   assign w_beat     = (r_state == ST_ARMED) && w_above && w_floor && w_rise;
   assign w_sum_next = r_sum + {{c_LOG2{1'b0}}, bus.flux_in_raw}
                             - {{c_LOG2{1'b0}}, r_buf[r_wp]};

`ifdef ONSET_RISING_EDGE_EN
   logic [W-1:0] r_prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_prev <= '0;
      else if (bus.flux_in_valid)
         r_prev <= bus.flux_in_raw;
   end

   assign w_rise = bus.flux_in_raw > r_prev;
`else
   assign w_rise = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < AVG_LEN; i++)
            r_buf[i] <= '0;
      end else if (bus.flux_in_valid) begin
         r_buf[r_wp] <= bus.flux_in_raw;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_WARMUP;
         r_rcnt       <= '0;
         r_wp         <= '0;
         r_sum        <= '0;
         r_flux_valid <= 1'b0;
         r_beat_valid <= 1'b0;
         r_flux_out   <= '0;
      end else begin
         r_flux_valid <= bus.flux_in_valid;
         r_beat_valid <= bus.flux_in_valid && w_beat;
         if (bus.flux_in_valid) begin
            r_flux_out <= bus.flux_in_raw;
            r_sum      <= w_sum_next;
            r_wp       <= r_wp + 1'b1;
            case (r_state)
               // The write pointer starts at zero, so it doubles as the fill count
               ST_WARMUP: begin
                  if (r_wp == c_WP_LAST)
                     r_state <= ST_ARMED;
               end
               ST_ARMED: begin
                  if (w_beat) begin
                     r_rcnt  <= c_REFR;
                     r_state <= ST_REFRACT;
                  end
               end
               ST_REFRACT: begin
                  r_rcnt <= r_rcnt - 1'b1;
                  if (r_rcnt == 8'd1)
                     r_state <= ST_ARMED;
               end
               default: r_state <= ST_WARMUP;
            endcase
         end
      end
   end

   assign bus.flux_valid = r_flux_valid;
   assign bus.flux_out   = r_flux_out;
   assign bus.beat_valid = r_beat_valid;
   assign bus.mean_out   = w_mean;
   assign bus.state_out  = r_state;
endmodule
`default_nettype wire
